// File: rtl/conv_bitserial_acc_pkg.sv
// Shared definitions for the bit-serial convolution accumulator.
// Holds the FSM state encoding and the default operand / accumulator sizing.
// No logic; imported by every file of the block.
package conv_bitserial_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no beat of the current operand taken yet
        ST_ACC  = 2'd1,   // at least one plane accumulated
        ST_HOLD = 2'd2    // result presented, waiting for out_ready
    } conv_state_e;

    localparam int CONV_NBITS_DEF  = 8;
    // Guard bits above NBITS: a beat adds up to 3 per plane, so the sum
    // needs headroom beyond a plain NBITS-bit operand.
    localparam int CONV_ACC_GUARD  = 3;
    localparam int CONV_ACC_W_DEF  = CONV_NBITS_DEF + CONV_ACC_GUARD;

endpackage

// File: rtl/conv_bitserial_acc_shift_add.sv
// Shift-add step of the bit-serial accumulator (purely combinational).
// Ports: acc_in (current sum), v (LUT beat 0..3), first (first plane of operand),
//        acc_out = first ? (+/-)v : (acc_in << 1) + v, all modulo 2^ACC_W.
module conv_shift_add
    import conv_bitserial_acc_pkg::*;
#(
    parameter int ACC_W       = CONV_ACC_W_DEF,
    parameter int SIGNED_MODE = 1
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [1:0]       v,
    input  logic             first,
    output logic [ACC_W-1:0] acc_out
);

    logic [ACC_W-1:0] v_ext;

    assign v_ext = ACC_W'(v);

    always_comb begin
        acc_out = '0;
        if (first) begin
            // In two's complement the MSB plane carries negative weight; seeding
            // with -v lets later doublings scale it to -v * 2^(planes-1).
            acc_out = (SIGNED_MODE != 0) ? ('0 - v_ext) : v_ext;
        end else begin
            acc_out = (acc_in << 1) + v_ext;
        end
    end

endmodule

// File: rtl/conv_bitserial_acc.sv
// Bit-serial accumulator: folds MSB-first LUT result beats into one ACC_W-bit result.
// Ports: clk/rst (async active-high); in_valid/in_ready/lut_bit1/lut_bit2/in_last beat
//        input; out_valid/out_ready/out_data/out_overrun result output (1-cycle latency).
module conv_bitserial_acc
    import conv_bitserial_acc_pkg::*;
#(
    parameter int NBITS       = CONV_NBITS_DEF,
    parameter int ACC_W       = NBITS + CONV_ACC_GUARD,
    parameter int SIGNED_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             lut_bit1,
    input  logic             lut_bit2,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_overrun
);

    localparam int CNT_W = $clog2(NBITS + 1);

    conv_state_e      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_full;
    logic [ACC_W-1:0] acc_sum;

    // All outputs come straight from flops, so no input reaches them combinationally.
    assign in_ready    = (state_q != ST_HOLD);
    assign out_valid   = (state_q == ST_HOLD);
    assign out_data    = acc_q;
    assign out_overrun = overrun_q;

    assign accept   = in_valid && (state_q != ST_HOLD);
    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_full = (cnt_inc == CNT_W'(NBITS));

    conv_shift_add #(
        .ACC_W       (ACC_W),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_shift_add (
        .acc_in  (acc_q),
        .v       ({lut_bit2, lut_bit1}),
        .first   (state_q == ST_IDLE),
        .acc_out (acc_sum)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        unique case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (in_last || cnt_full) begin
                        state_d   = ST_HOLD;
                        // Overrun only when the plane budget, not the producer, closed it.
                        overrun_d = !in_last;
                    end else begin
                        state_d = ST_ACC;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    acc_d     = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                acc_d     = '0;
                cnt_d     = '0;
                overrun_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_conv_bitserial_acc.sv
// Bench for conv_bitserial_acc: unsigned and signed instances (NBITS=4, ACC_W=7)
// share one stimulus stream; results are compared against an arithmetic model.
// Directed cases first, then randomized operands with gaps and output stalls.
module tb_conv_bitserial_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       lut_bit1 = 1'b0;
    logic       lut_bit2 = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy_u, rdy_s, ov_u, ov_s, orun_u, orun_s;
    logic [6:0] dat_u, dat_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    conv_bitserial_acc #(.NBITS(4), .ACC_W(7), .SIGNED_MODE(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u),
        .lut_bit1(lut_bit1), .lut_bit2(lut_bit2), .in_last(in_last),
        .out_valid(ov_u), .out_ready(out_ready), .out_data(dat_u), .out_overrun(orun_u)
    );

    conv_bitserial_acc #(.NBITS(4), .ACC_W(7), .SIGNED_MODE(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
        .lut_bit1(lut_bit1), .lut_bit2(lut_bit2), .in_last(in_last),
        .out_valid(ov_s), .out_ready(out_ready), .out_data(dat_s), .out_overrun(orun_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; presents one beat for exactly one edge.
    task automatic beat(input int v, input bit last);
        in_valid = 1'b1;
        lut_bit1 = v[0];
        lut_bit2 = v[1];
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        lut_bit1 = 1'b0;
        lut_bit2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_hold(input string tag, input int eu, input int es, input bit eo);
        chk({tag, "_vld_u"}, ov_u, 1);
        chk({tag, "_vld_s"}, ov_s, 1);
        chk({tag, "_dat_u"}, dat_u, eu & 127);
        chk({tag, "_dat_s"}, dat_s, es & 127);
        chk({tag, "_ovr_u"}, orun_u, eo);
        chk({tag, "_ovr_s"}, orun_s, eo);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_rel_vld"}, ov_u | ov_s, 0);
        chk({tag, "_rel_rdy"}, rdy_u & rdy_s, 1);
    endtask

    // Value of an operand: plane i of L weighs 2^(L-1-i); in signed mode the
    // first plane weighs negatively. Reduced to the 7-bit result width.
    function automatic int model(input int vs[4], input int len, input bit sgn);
        int val = 0;
        for (int i = 0; i < len; i++) begin
            int w = 1 << (len - 1 - i);
            if (i == 0 && sgn) val -= vs[i] * w;
            else               val += vs[i] * w;
        end
        return val & 127;
    endfunction

    initial begin
        int vs[4];
        int len;
        bit use_last;
        int eu, es;

        // Reset state
        #2;
        chk("rst_vld", ov_u | ov_s, 0);
        chk("rst_dat_u", dat_u, 0);
        chk("rst_dat_s", dat_s, 0);
        chk("rst_ovr", orun_u | orun_s, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rdy", rdy_u & rdy_s, 1);

        // 1,0,1,1 with in_last on beat 4: 11 unsigned, -5 signed
        beat(1, 0);
        beat(0, 0);
        beat(1, 0);
        chk("b1011_early_vld", ov_u | ov_s, 0);
        beat(1, 1);
        chk_hold("b1011", 11, -5, 0);

        // Stall in HOLD with a beat offered: nothing accepted, result stable
        in_valid = 1'b1;
        lut_bit1 = 1'b1;
        lut_bit2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_rdy", rdy_u | rdy_s, 0);
            chk("stall_vld", ov_u & ov_s, 1);
            chk("stall_dat_u", dat_u, 11);
            chk("stall_dat_s", dat_s, 7'h7B);
        end
        in_valid = 1'b0;
        lut_bit1 = 1'b0;
        lut_bit2 = 1'b0;
        release_out("b1011");

        // 3,2 closed by in_last: 8 unsigned, -4 signed
        beat(3, 0);
        beat(2, 1);
        chk_hold("b32", 8, -4, 0);
        release_out("b32");

        // Four beats without in_last: closed by plane count
        for (int i = 0; i < 4; i++) beat(1, 0);
        chk_hold("ovr", 15, -1, 1);
        release_out("ovr");

        // Reset mid-operand discards the partial sum
        beat(1, 0);
        beat(1, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_vld", ov_u | ov_s, 0);
        chk("rst_mid_dat", dat_u | dat_s, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        chk("rst_mid_novld", ov_u | ov_s, 0);
        beat(2, 0);
        beat(0, 0);
        beat(0, 0);
        beat(1, 1);
        chk_hold("b2001", 17, -15, 0);
        release_out("b2001");

        // Single-plane operand, then reset while holding
        beat(3, 1);
        chk_hold("single", 3, -3, 0);
        rst = 1'b1;
        #1;
        chk("rst_hold_vld", ov_u | ov_s, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk("rst_hold_novld", ov_u | ov_s, 0);
        chk("rst_hold_rdy", rdy_u & rdy_s, 1);

        // Randomized operands with inter-beat gaps and output stalls
        for (int op = 0; op < 30; op++) begin
            len = $urandom_range(1, 4);
            use_last = (len < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) vs[i] = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                idle($urandom_range(0, 2));
                beat(vs[i], use_last && (i == len - 1));
            end
            eu = model(vs, len, 1'b0);
            es = model(vs, len, 1'b1);
            chk_hold("rnd", eu, es, !use_last);
            idle($urandom_range(0, 3));
            chk("rnd_stall_dat_u", dat_u, eu);
            chk("rnd_stall_dat_s", dat_s, es);
            release_out("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
